// File: rtl/cam_capture_ds_pkg.sv
// rtl/cam_capture_ds_pkg.sv - shared encodings and field widths for the camera capture path
package cam_capture_ds_pkg;

  // Source format codes as presented on the fmt port
  localparam logic [1:0] FMT_RGB565 = 2'b00;
  localparam logic [1:0] FMT_RGB444 = 2'b01;
  localparam logic [1:0] FMT_Y      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Per-component widths of the supported buffer colour depths
  localparam int RGB332_R_BITS = 3;
  localparam int RGB332_G_BITS = 3;
  localparam int RGB332_B_BITS = 2;
  localparam int RGB444_R_BITS = 4;
  localparam int RGB444_G_BITS = 4;
  localparam int RGB444_B_BITS = 4;
  localparam int RGB565_R_BITS = 5;
  localparam int RGB565_G_BITS = 6;
  localparam int RGB565_B_BITS = 5;

  function automatic int r_bits(input int dw);
    return (dw == 8) ? RGB332_R_BITS : (dw == 12) ? RGB444_R_BITS : RGB565_R_BITS;
  endfunction

  function automatic int g_bits(input int dw);
    return (dw == 8) ? RGB332_G_BITS : (dw == 12) ? RGB444_G_BITS : RGB565_G_BITS;
  endfunction

  function automatic int b_bits(input int dw);
    return (dw == 8) ? RGB332_B_BITS : (dw == 12) ? RGB444_B_BITS : RGB565_B_BITS;
  endfunction

endpackage

// File: rtl/cam_capture_ds_pix_convert.sv
// rtl/cam_capture_ds_pix_convert.sv - combinational byte-pair to buffer-word colour conversion
module cam_capture_ds_pix_convert
  import cam_capture_ds_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [1:0]    fmt,
  input  logic [7:0]    hi,
  input  logic [7:0]    lo,
  output logic [DW-1:0] pix
);

  localparam int RB = r_bits(DW);
  localparam int GB = g_bits(DW);
  localparam int BB = b_bits(DW);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  // Expand every source format to RGB565-equivalent components; reserved code falls back to RGB565
  always_comb begin
    r5 = hi[7:3];
    g6 = {hi[2:0], lo[7:5]};
    b5 = lo[4:0];
    case (fmt)
      FMT_RGB444: begin
        r5 = {hi[3:0], hi[3]};
        g6 = {lo[7:4], lo[7:6]};
        b5 = {lo[3:0], lo[3]};
      end
      FMT_Y: begin
        r5 = hi[7:3];
        g6 = hi[7:2];
        b5 = hi[7:3];
      end
      default: ;
    endcase
  end

  // Narrower buffer depths keep only the component MSBs
  assign pix = {r5[4 -: RB], g6[5 -: GB], b5[4 -: BB]};

  // Low component bits are intentionally dropped for narrow DW
  logic unused_bits;
  assign unused_bits = ^{r5, g6, b5};

endmodule

// File: rtl/cam_capture_ds.sv
// rtl/cam_capture_ds.sv - OV7670 capture, pixel assembly, decimation and frame-buffer write port
module cam_capture_ds
  import cam_capture_ds_pkg::*;
#(
  parameter int CAM_W = 640,
  parameter int CAM_H = 480,
  parameter int DEC_X = 4,
  parameter int DEC_Y = 4,
  parameter int DW    = 8,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          cont,
  input  logic [1:0]    fmt,
  input  logic          href,
  input  logic          vsync,
  input  logic [7:0]    d,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          err
);

  // Counters saturate one past the active size so overrun stays detectable
  localparam int CW = $clog2(CAM_W + 1);
  localparam int RW = $clog2(CAM_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(CAM_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(CAM_H);
  localparam logic [CW-1:0] X_MASK  = CW'(DEC_X - 1);
  localparam logic [RW-1:0] Y_MASK  = RW'(DEC_Y - 1);

  state_t        state;
  logic          vsync_d, href_d, arm_d;
  logic [1:0]    fmt_q;
  logic          phase;
  logic [7:0]    hi_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] pix;

  logic arm_rise, vsync_rise, vsync_fall, href_fall, in_range, on_grid;

  assign arm_rise   = arm & ~arm_d;
  assign vsync_rise = vsync & ~vsync_d;
  assign vsync_fall = ~vsync & vsync_d;
  assign href_fall  = ~href & href_d;
  assign in_range   = (col < COL_MAX) && (row < ROW_MAX);
  assign on_grid    = ((col & X_MASK) == '0) && ((row & Y_MASK) == '0);

  cam_capture_ds_pix_convert #(.DW(DW)) u_conv (
    .fmt (fmt_q),
    .hi  (hi_q),
    .lo  (d),
    .pix (pix)
  );

  // Delayed copies for edge detection; arm_d starts high so a level held through reset is not a new arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      arm_d   <= 1'b1;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
      arm_d   <= arm;
    end
  end

  // Capture FSM with pixel assembly, decimation, addressing and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      fmt_q      <= FMT_RGB565;
      phase      <= 1'b0;
      hi_q       <= '0;
      col        <= '0;
      row        <= '0;
      wr_ptr     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= 1'b0;
      if (arm_rise) err <= 1'b0;
      if (!arm) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm_rise) state <= ST_WAIT_VS;
          end
          ST_WAIT_VS: begin
            if (vsync_fall) begin
              state  <= ST_ACTIVE;
              busy   <= 1'b1;
              fmt_q  <= fmt;
              col    <= '0;
              row    <= '0;
              wr_ptr <= '0;
              phase  <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (href) begin
              if (!phase) begin
                hi_q  <= d;
                phase <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (col < COL_MAX) col <= col + 1'b1;
                if (!in_range) begin
                  err <= 1'b1;
                end else if (on_grid) begin
                  ram_we   <= 1'b1;
                  ram_addr <= wr_ptr;
                  ram_data <= pix;
                  wr_ptr   <= wr_ptr + 1'b1;
                end
              end
            end else if (href_fall) begin
              phase <= 1'b0;
              col   <= '0;
              if (row < ROW_MAX) row <= row + 1'b1;
              if (phase) err <= 1'b1;
            end
            if (vsync_rise) begin
              state      <= ST_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
            end
          end
          ST_DONE: begin
            state <= cont ? ST_WAIT_VS : ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ds.sv
// tb/tb_cam_capture_ds.sv - directed scoreboard bench for cam_capture_ds
module tb_cam_capture_ds;

  localparam int CAM_W = 8;
  localparam int CAM_H = 4;
  localparam int DEC_X = 2;
  localparam int DEC_Y = 2;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, arm, cont, href, vsync;
  logic [1:0]    fmt;
  logic [7:0]    d;
  logic          ram_we, busy, frame_done, err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;
  int max_addr = 0;
  int exp_addr, mrow, exp_fcnt, exp_fd;
  logic [1:0] mfmt;
  bit exp_err;
  logic [AW+DW-1:0] sb[$];

  cam_capture_ds #(
    .CAM_W(CAM_W), .CAM_H(CAM_H), .DEC_X(DEC_X), .DEC_Y(DEC_Y), .DW(DW), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .cont(cont), .fmt(fmt), .href(href),
    .vsync(vsync), .d(d), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [1:0] f, input logic [7:0] h, input logic [7:0] l);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    case (f)
      2'b01:   begin r = {h[3:0], h[3]}; g = {l[7:4], l[7:6]}; b = {l[3:0], l[3]}; end
      2'b10:   begin r = h[7:3]; g = h[7:2]; b = h[7:3]; end
      default: begin r = h[7:3]; g = {h[2:0], l[7:5]}; b = l[4:0]; end
    endcase
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  // Every write the DUT makes must match the head of the scoreboard
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_pulses++;
    if (ram_we === 1'b1) begin
      if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      if (sb.size() == 0) chk("unexpected_write", 32'(ram_we), 32'd0);
      else chk("write", 32'({ram_addr, ram_data}), 32'(sb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    arm = 1'b0;
    tick();
    arm = 1'b1;
    tick();
    exp_err = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] f);
    fmt = f;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    exp_addr = 0;
    mrow = 0;
    mfmt = f;
  endtask

  task automatic end_frame(input string tag);
    vsync = 1'b1;
    tick();
    chk({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    tick();
    chk({tag, "_done_low"}, 32'(frame_done), 32'd0);
    exp_fcnt++;
    exp_fd++;
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fcnt));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic send_line(input int nbytes, input bit cap, input bit rnd,
                           input logic [7:0] hi0, input logic [7:0] lo0);
    logic [7:0] hb, lb;
    int c;
    bit keep;
    hb = hi0;
    for (int i = 0; i < nbytes; i++) begin
      href = 1'b1;
      if (i % 2 == 0) begin
        hb = (i == 0 || !rnd) ? hi0 : 8'($urandom);
        d = hb;
        tick();
      end else begin
        lb = (i == 1 || !rnd) ? lo0 : 8'($urandom);
        d = lb;
        c = i / 2;
        keep = cap && c < CAM_W && mrow < CAM_H && c % DEC_X == 0 && mrow % DEC_Y == 0;
        if (cap && !(c < CAM_W && mrow < CAM_H)) exp_err = 1'b1;
        if (keep) begin
          sb.push_back({AW'(exp_addr), conv(mfmt, hb, lb)});
          exp_addr++;
        end
        tick();
        chk("we_latency", 32'(ram_we), 32'(keep));
      end
    end
    href = 1'b0;
    tick();
    if (cap && (nbytes % 2 == 1)) exp_err = 1'b1;
    mrow++;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; cont = 1'b0; href = 1'b0; vsync = 1'b1; fmt = 2'b00; d = 8'h00;
    exp_fcnt = 0; exp_fd = 0; exp_err = 1'b0; exp_addr = 0; mrow = 0; mfmt = 2'b00;
    tick();
    tick();
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Red RGB565 frame, single shot
    arm = 1'b1;
    tick();
    start_frame(2'b00);
    chk("busy_active", 32'(busy), 32'd1);
    for (int l = 0; l < CAM_H; l++) send_line(2 * CAM_W, 1'b1, 1'b0, 8'hF8, 8'h00);
    end_frame("red565");
    chk("last_addr", 32'(ram_addr), 32'd7);
    chk("busy_idle", 32'(busy), 32'd0);

    // Second frame with cont=0 must be ignored
    start_frame(2'b00);
    chk("single_shot_busy", 32'(busy), 32'd0);
    send_line(2 * CAM_W, 1'b0, 1'b1, 8'h12, 8'h34);
    vsync = 1'b1;
    tick();
    tick();
    chk("single_shot_fcnt", 32'(frame_cnt), 32'(exp_fcnt));

    // RGB444 red then random pixels
    rearm();
    start_frame(2'b01);
    for (int l = 0; l < 3; l++) send_line(2 * CAM_W, 1'b1, 1'b1, 8'h0F, 8'h00);
    end_frame("rgb444");

    // Luma only, white first pixel
    rearm();
    start_frame(2'b10);
    for (int l = 0; l < 3; l++) send_line(2 * CAM_W, 1'b1, 1'b1, 8'hFF, 8'h80);
    end_frame("yuv");

    // Reserved format behaves as RGB565
    rearm();
    start_frame(2'b11);
    send_line(2 * CAM_W, 1'b1, 1'b1, 8'hA5, 8'h5A);
    end_frame("fmt11");

    // Odd-length line
    rearm();
    chk("err_cleared", 32'(err), 32'd0);
    start_frame(2'b00);
    send_line(11, 1'b1, 1'b1, 8'h07, 8'hE0);
    chk("odd_err", 32'(err), 32'd1);
    send_line(2 * CAM_W, 1'b1, 1'b1, 8'h11, 8'h22);
    send_line(2 * CAM_W, 1'b1, 1'b1, 8'h33, 8'h44);
    end_frame("odd");

    // Overlong lines and an extra line
    rearm();
    start_frame(2'b00);
    for (int l = 0; l < CAM_H + 1; l++) send_line(2 * (CAM_W + 2), 1'b1, 1'b1, 8'hC3, 8'h3C);
    end_frame("overrun");
    chk("max_addr", 32'(max_addr), 32'd7);

    // Continuous capture, address restarts each frame
    rearm();
    cont = 1'b1;
    start_frame(2'b00);
    for (int l = 0; l < CAM_H; l++) send_line(2 * CAM_W, 1'b1, 1'b1, 8'h5F, 8'hF5);
    end_frame("cont1");
    start_frame(2'b00);
    chk("cont_busy", 32'(busy), 32'd1);
    for (int l = 0; l < CAM_H; l++) send_line(2 * CAM_W, 1'b1, 1'b1, 8'hE1, 8'h1E);
    end_frame("cont2");

    // Asynchronous reset during a write
    start_frame(2'b00);
    href = 1'b1;
    d = 8'hF8;
    tick();
    d = 8'h00;
    tick();
    chk("pre_rst_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_we", 32'(ram_we), 32'd0);
    chk("async_addr", 32'(ram_addr), 32'd0);
    chk("async_data", 32'(ram_data), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_fcnt", 32'(frame_cnt), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    href = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start_frame(2'b00);
    chk("no_rearm_busy", 32'(busy), 32'd0);
    send_line(2 * CAM_W, 1'b0, 1'b1, 8'h77, 8'h88);
    vsync = 1'b1;
    tick();
    tick();
    chk("no_rearm_fcnt", 32'(frame_cnt), 32'd0);
    chk("fd_pulses", 32'(fd_pulses), 32'(exp_fd));
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_capture_ds.md
# cam_capture_ds

Parametrised camera capture and downsampler. Sits between the OV7670 parallel pixel bus and the write port of the dual-port frame buffer. It assembles two-byte pixels, decimates by DEC_X × DEC_Y, and converts to the buffer colour depth DW. It generates linear write addresses and adds arm/single-shot control, frame-done signalling and error flags.

## Interface
Parameters:
- CAM_W, 640, active source pixels per line
- CAM_H, 480, active source lines per frame
- DEC_X, 4, horizontal decimation factor (power of two, ≥1)
- DEC_Y, 4, vertical decimation factor (power of two, ≥1)
- DW, 8, buffer word width: 8 = RGB332, 12 = RGB444, 16 = RGB565
- AW, 15, buffer address width; must satisfy 2^AW ≥ (CAM_W/DEC_X)·(CAM_H/DEC_Y)

Ports:
- clk  in  1  camera pixel clock (Pclk at top level); all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- arm  in  1  level; while high, capture is allowed
- cont  in  1  1 = continuous frames, 0 = single shot
- fmt  in  2  source format: 00 RGB565, 01 RGB444 (xR/GB), 10 YUV422 luma only, 11 reserved (treated as 00)
- href  in  1  camera line-valid
- vsync  in  1  camera frame sync (high = vertical blank)
- d  in  8  camera data byte
- ram_we  out  1  buffer write enable
- ram_addr  out  AW  buffer write address
- ram_data  out  DW  buffer write data
- busy  out  1  high in ACTIVE
- frame_done  out  1  one-cycle pulse at end of captured frame
- frame_cnt  out  8  captured-frame counter, wraps 255→0
- err  out  1  sticky protocol error; cleared only by rst or a new arm rising edge

## Operation
- States:
  - IDLE: arm rising edge → WAIT_VS.
  - WAIT_VS: vsync falling edge → ACTIVE; fmt latched here.
  - ACTIVE: vsync rising edge → DONE.
  - DONE (one cycle):
    - frame_done=1 and frame_cnt+1.
    - Next state is WAIT_VS if cont=1 and arm=1; otherwise IDLE.
- arm low in any state → IDLE at the next edge. Any partial frame is abandoned without frame_done.
- Byte pairing in ACTIVE:
  - Bytes sampled while href=1; byte phase toggles per byte, first byte = high byte.
  - Phase resets on href falling.
  - href falling with phase odd → partial pixel discarded, err=1.
- Counters:
  - col counts assembled pixels in the line; row counts lines (increments on href falling).
  - Both are cleared on the WAIT_VS→ACTIVE transition.
- Keep rule: pixel is written only if col%DEC_X==0 and row%DEC_Y==0. Implement with low-bit masks, not division.
- Address:
  - Incremented by 1 per kept pixel; starts at 0 each frame.
  - No multiplier.
- Overrun: col ≥ CAM_W or row ≥ CAM_H → pixel dropped (no write), err=1. Address never exceeds (CAM_W/DEC_X)(CAM_H/DEC_Y)−1.
- Short lines/frames are accepted without error; the next line restarts col at 0.
- Conversion, from source to RGB565-equivalent components R5 G6 B5:
  - 01: R4→R5 by {r,r[3]}; G4→G6 by {g,g[3:2]}; B4→B5 by {b,b[3]}.
  - 10: first byte Y; R5=Y[7:3], G6=Y[7:2], B5=Y[7:3].
  - Output truncates MSBs: DW=8 {R[4:2],G[5:3],B[4:3]}; DW=12 {R[4:1],G[5:2],B[4:1]}; DW=16 {R,G,B}.

## Timing
- Reset values:
  - ram_we=0, ram_addr=0, ram_data=0.
  - busy=0, frame_done=0, frame_cnt=0, err=0.
  - state IDLE, all counters 0.
- Write latency: ram_we/ram_addr/ram_data registered and valid the cycle after the second byte is sampled. ram_we is high for exactly one cycle.
- ram_addr holds the address of the write in progress. It advances after the write.
- vsync/href edges are detected against one-cycle-delayed copies, so each edge is acted on one cycle after it occurs.
- Simultaneous events:
  - vsync rising in the same cycle as a second byte → the pixel is written, then DONE.
  - arm low in the same cycle as DONE → frame_done still pulses, then IDLE.
- rst mid-frame: all outputs return to reset values immediately (asynchronous reset).

## Structure
- Shared package holds the fmt encodings (FMT_RGB565, FMT_RGB444, FMT_Y), the state encodings, and the RGB332/444/565 bit-field constants.
- One sub-module is natural: pix_convert. It is purely combinational and maps {fmt, hi, lo} to DW bits.

## Test plan
- Reset, then CAM_W=8, CAM_H=4, DEC=2×2, DW=8, fmt=00, pixel 0xF800 → 8 writes at addr 0..7, red pixels write data 0xE0; frame_done one pulse; frame_cnt=1.
- fmt=01 byte pair 0x0F,0x00 (pure red) → written data 0xE0. fmt=10 Y=0xFF → 0xFF.
- Line with 11 bytes (odd) → last byte dropped, err=1, next line correct.
- 10-pixel line with CAM_W=8 → only the kept pixels of cols 0..7 written; err=1; max address not exceeded.
- cont=0, two frames sent → only the first captured, frame_cnt=1, state IDLE. cont=1 → frame_cnt=2, addr restarts at 0 in frame 2.
- rst asserted mid-line → outputs 0 in the same cycle. After release with arm high and no new rising edge, state remains IDLE.
